// File: rtl/ftdi_rx_fb_gen_if.sv
// FTDI FT245 synchronous FIFO pins plus framebuffer write port, grouped as one bundle.
// master = the receiver; slave = FTDI chip and framebuffer side.
interface ftdi_rx_fb_gen_if #(
    parameter int PIX_W  = 20,
    parameter int ADDR_W = 14,
    parameter int ERR_W  = 8
) ();
    logic [7:0]        data_in;
    logic              rxf_n;
    logic              txe_n;
    logic              rd_n;
    logic              oe_n;
    logic              wr_n;
    logic [PIX_W-1:0]  fb_wdata;
    logic [ADDR_W-1:0] fb_waddr;
    logic              fb_we;
    logic              full;
    logic              swapped;
    logic              frame_err;
    logic [ERR_W-1:0]  err_count;

    modport master (
        input  data_in, rxf_n, txe_n, swapped,
        output rd_n, oe_n, wr_n, fb_wdata, fb_waddr, fb_we, full, frame_err, err_count
    );

    modport slave (
        output data_in, rxf_n, txe_n, swapped,
        input  rd_n, oe_n, wr_n, fb_wdata, fb_waddr, fb_we, full, frame_err, err_count
    );
endinterface

// File: rtl/ftdi_rx_fb_gen.sv
// FTDI FIFO to framebuffer receiver: packs CHANNELS flagged bytes per pixel, stops at frame-full,
// discards bytes until the first start flag and counts short/misaligned frames.
//
// state | meaning
// IDLE  | bus released, waiting for data and a free frame
// START | output enable asserted one cycle before the first read strobe
// READ  | read strobe low, one byte accepted per cycle while rxf_n is low
module ftdi_rx_fb_gen #(
    parameter int CHANNELS     = 3,
    parameter int CH_BITS      = 7,
    parameter int PIX_W        = 20,
    parameter int ADDR_W       = 14,
    parameter int FRAME_PIXELS = 16384,
    parameter int ERR_W        = 8
) (
    input  logic              clk_60,
    input  logic              rst_n,
    ftdi_rx_fb_gen_if.master  bus
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int K  = PIX_W - (CHANNELS - 1) * CH_BITS;
    localparam logic [CW-1:0]     LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  pix_cnt;
    logic [CW-1:0]      ch_idx;
    logic               synced;
    logic               full_r;
    logic               fb_we_r;
    logic               frame_err_r;
    logic [ERR_W-1:0]   err_cnt;
    logic [PIX_W-1:0]   wdata_r;
    logic [CH_BITS-1:0] ch_r [CHANNELS-1];

    logic               accept;
    logic               take;
    logic               is_flag;
    logic               pix_done;
    logic               last_byte;
    logic               full_set;
    logic               misalign;
    logic [CH_BITS-1:0] payload;
    logic [PIX_W-1:0]   pix_word;
    logic               oe_n_c;
    logic               rd_n_c;
    logic               unused_txe;

    assign accept    = (state == READ) && !bus.rxf_n;
    assign take      = accept && !bus.swapped;
    assign is_flag   = bus.data_in[7];
    assign payload   = bus.data_in[CH_BITS-1:0];
    assign pix_done  = take && !is_flag && synced && (ch_idx == LAST_CH);
    assign last_byte = pix_done && (pix_cnt == LAST_PIX);
    assign full_set  = fb_we_r && (pix_cnt == LAST_PIX) && !bus.swapped;
    // A pixel still being written counts as progress, so a flag landing in the fb_we cycle is short.
    assign misalign  = take && is_flag && synced &&
                       (fb_we_r || (pix_cnt != '0) || (ch_idx != '0));

    always_comb begin
        pix_word = '0;
        for (int i = 0; i < CHANNELS - 1; i++) begin
            pix_word[PIX_W-1-i*CH_BITS -: CH_BITS] = ch_r[i];
        end
        pix_word[K-1:0] = bus.data_in[K-1:0];
    end

    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        oe_n_c    = 1'b1;
        rd_n_c    = 1'b1;
        case (state)
            IDLE: begin
                // Hold off while the frame-completing write is still in flight.
                if (!bus.rxf_n && !full_r && !full_set) begin
                    state_nxt = START;
                end
            end
            START: begin
                oe_n_c    = 1'b0;
                state_nxt = bus.rxf_n ? IDLE : READ;
            end
            READ: begin
                oe_n_c = 1'b0;
                rd_n_c = 1'b0;
                if (bus.rxf_n || last_byte) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            ch_idx      <= '0;
            synced      <= 1'b0;
            full_r      <= 1'b0;
            fb_we_r     <= 1'b0;
            frame_err_r <= 1'b0;
            err_cnt     <= '0;
            wdata_r     <= '0;
            for (int i = 0; i < CHANNELS - 1; i++) begin
                ch_r[i] <= '0;
            end
        end else begin
            fb_we_r     <= pix_done;
            frame_err_r <= misalign;
            if (misalign && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (pix_done) begin
                wdata_r <= pix_word;
            end
            if (take && is_flag) begin
                synced <= 1'b1;
            end
            if (take && (is_flag || synced)) begin
                for (int i = 0; i < CHANNELS - 1; i++) begin
                    if (is_flag ? (i == 0) : (ch_idx == CW'(i))) begin
                        ch_r[i] <= payload;
                    end
                end
            end

            if (bus.swapped) begin
                pix_cnt <= '0;
                ch_idx  <= '0;
                full_r  <= 1'b0;
            end else begin
                if (take && is_flag) begin
                    ch_idx <= CW'(1);
                end else if (take && synced) begin
                    ch_idx <= (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;
                end
                if (take && is_flag) begin
                    pix_cnt <= '0;
                end else if (fb_we_r) begin
                    pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
                end
                if (full_set) begin
                    full_r <= 1'b1;
                end
            end
        end
    end

    assign bus.oe_n      = oe_n_c;
    assign bus.rd_n      = rd_n_c;
    assign bus.wr_n      = 1'b1;
    assign bus.fb_wdata  = wdata_r;
    assign bus.fb_waddr  = pix_cnt;
    assign bus.fb_we     = fb_we_r;
    assign bus.full      = full_r;
    assign bus.frame_err = frame_err_r;
    assign bus.err_count = err_cnt;

    // txe_n only exists so the pinout matches the FT245 footprint.
    assign unused_txe = bus.txe_n;

endmodule
